// File: rtl/count_pkg.sv
// Shared constants and helpers for the cascaded modulo counter chain.
package count_pkg;

  localparam int unsigned MOD_BITS   = 8;
  localparam int unsigned MAX_STAGES = 8;
  localparam int unsigned MODS_W     = MOD_BITS * MAX_STAGES;

  // Extract the modulus of stage i from the packed MODS vector (stage 0 in the LSBs).
  function automatic logic [MOD_BITS-1:0] mod_of(input logic [MODS_W-1:0] mods,
                                                 input int unsigned       i);
    return mods[i*MOD_BITS +: MOD_BITS];
  endfunction

  // Terminal digit value: top of range when counting up, zero when counting down.
  function automatic logic [MOD_BITS-1:0] term_val(input logic [MOD_BITS-1:0] m,
                                                   input logic                up_dn);
    return up_dn ? (m - MOD_BITS'(1)) : '0;
  endfunction

endpackage

// File: rtl/count_digit.sv
// One mod-MOD up/down counter digit with clear, saturating load and step enable.
module count_digit
  import count_pkg::*;
#(
  parameter int unsigned          CNT_W = 4,
  parameter logic [MOD_BITS-1:0]  MOD   = 8'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             is_term,
  output logic             term_nxt_c
);

  localparam logic [MOD_BITS-1:0] TOP = MOD - MOD_BITS'(1);

  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [MOD_BITS-1:0] term_c;

  assign term_c = term_val(MOD, up_dn);

  // Next digit value: clear beats load beats step; load saturates out-of-range data.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if (MOD_BITS'(load_val) >= MOD) cnt_d = CNT_W'(TOP);
      else                            cnt_d = load_val;
    end else if (step) begin
      if (up_dn) begin
        if (MOD_BITS'(cnt_q) == TOP) cnt_d = '0;
        else                         cnt_d = cnt_q + CNT_W'(1);
      end else begin
        if (cnt_q == '0) cnt_d = CNT_W'(TOP);
        else             cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt        = cnt_q;
  assign is_term    = (MOD_BITS'(cnt_q) == term_c);
  assign term_nxt_c = (MOD_BITS'(cnt_d) == term_c);

endmodule

// File: rtl/count_mod_chain.sv
// Cascade of modulo digits with up/down, clear, load, chain-terminal flag and wrap pulse.
module count_mod_chain
  import count_pkg::*;
#(
  parameter int unsigned                  STAGES = 2,
  parameter int unsigned                  CNT_W  = 4,
  parameter logic [STAGES*MOD_BITS-1:0]   MODS   = {8'd6, 8'd10}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  input  logic                    load,
  input  logic [STAGES*CNT_W-1:0] load_val,
  output logic [STAGES*CNT_W-1:0] count,
  output logic                    co_flag,
  output logic                    co_pulse
);

  logic [STAGES-1:0] step_c;
  logic [STAGES-1:0] is_term;
  logic [STAGES-1:0] term_nxt;
  logic              all_term_c;
  logic              co_flag_q, co_flag_d;
  logic              co_pulse_q, co_pulse_d;

  // Step-enable chain: a stage advances only when every lower stage is terminal.
  always_comb begin
    logic acc;
    acc = en;
    for (int i = 0; i < int'(STAGES); i++) begin
      step_c[i] = acc;
      acc       = acc & is_term[i];
    end
  end

  for (genvar gi = 0; gi < int'(STAGES); gi++) begin : g_digit
    count_digit #(
      .CNT_W (CNT_W),
      .MOD   (mod_of(MODS_W'(MODS), gi))
    ) u_digit (
      .clk        (clk),
      .rst        (rst),
      .step       (step_c[gi]),
      .up_dn      (up_dn),
      .clr        (clr),
      .load       (load),
      .load_val   (load_val[gi*CNT_W +: CNT_W]),
      .cnt        (count[gi*CNT_W +: CNT_W]),
      .is_term    (is_term[gi]),
      .term_nxt_c (term_nxt[gi])
    );
  end

  assign all_term_c = &is_term;

  // Flag tracks the post-edge terminal state; pulse marks a counted full wrap only.
  always_comb begin
    co_flag_d  = &term_nxt;
    co_pulse_d = en & all_term_c & ~clr & ~load;
  end

  // Chain status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      co_flag_q  <= 1'b0;
      co_pulse_q <= 1'b0;
    end else begin
      co_flag_q  <= co_flag_d;
      co_pulse_q <= co_pulse_d;
    end
  end

  assign co_flag  = co_flag_q;
  assign co_pulse = co_pulse_q;

endmodule

// File: tb/tb_count_mod_chain.sv
// Bench for count_mod_chain: default 00..59 chain plus a 3-stage (2,6,10) chain.
module tb_count_mod_chain;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, clr, load;
  logic [7:0]  lv_a, cnt_a;
  logic [11:0] lv_b, cnt_b;
  logic        flag_a, pulse_a, flag_b, pulse_b;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  // Flat-value model: each chain is a single integer modulo its modulus product.
  int   va, vb;
  logic fa, fb, pa, pb;
  int   na, nb;

  localparam int PA = 60;
  localparam int PB = 120;

  always #5 clk = ~clk;

  count_mod_chain dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv_a), .count(cnt_a), .co_flag(flag_a), .co_pulse(pulse_a)
  );

  count_mod_chain #(.STAGES(3), .CNT_W(4), .MODS({8'd2, 8'd6, 8'd10})) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(lv_b), .count(cnt_b), .co_flag(flag_b), .co_pulse(pulse_b)
  );

  function automatic int step_v(int v, int p, logic up);
    return up ? (v + 1) % p : (v + p - 1) % p;
  endfunction

  function automatic logic term_v(int v, int p, logic up);
    return up ? (v == p - 1) : (v == 0);
  endfunction

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int sat_a(logic [7:0] lv);
    return min_i(int'(lv[7:4]), 5) * 10 + min_i(int'(lv[3:0]), 9);
  endfunction

  function automatic int sat_b(logic [11:0] lv);
    return min_i(int'(lv[11:8]), 1) * 60 + min_i(int'(lv[7:4]), 5) * 10
         + min_i(int'(lv[3:0]), 9);
  endfunction

  function automatic logic [7:0] pack_a(int v);
    logic [7:0] r;
    r[3:0] = 4'(v % 10);
    r[7:4] = 4'(v / 10);
    return r;
  endfunction

  function automatic logic [11:0] pack_b(int v);
    logic [11:0] r;
    r[3:0]  = 4'(v % 10);
    r[7:4]  = 4'((v / 10) % 6);
    r[11:8] = 4'(v / 60);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Model update on every rising edge from the inputs presented before it.
  always @(posedge clk) begin
    if (rst) begin
      va = 0; vb = 0; fa = 1'b0; fb = 1'b0; pa = 1'b0; pb = 1'b0;
    end else begin
      if (clr) begin
        va = 0; vb = 0; pa = 1'b0; pb = 1'b0;
      end else if (load) begin
        va = sat_a(lv_a); vb = sat_b(lv_b); pa = 1'b0; pb = 1'b0;
      end else if (en) begin
        pa = term_v(va, PA, up_dn);
        pb = term_v(vb, PB, up_dn);
        va = step_v(va, PA, up_dn);
        vb = step_v(vb, PB, up_dn);
      end else begin
        pa = 1'b0; pb = 1'b0;
      end
      fa = term_v(va, PA, up_dn);
      fb = term_v(vb, PB, up_dn);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      check("model_cnt_a",   32'(cnt_a),   32'(pack_a(va)));
      check("model_flag_a",  32'(flag_a),  32'(fa));
      check("model_pulse_a", 32'(pulse_a), 32'(pa));
      check("model_cnt_b",   32'(cnt_b),   32'(pack_b(vb)));
      check("model_flag_b",  32'(flag_b),  32'(fb));
      check("model_pulse_b", 32'(pulse_b), 32'(pb));
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    lv_a = '0; lv_b = '0;
    tick();
    checking = 1'b1;
    tick();
    check("reset_cnt",   32'(cnt_a),   32'h00);
    check("reset_flag",  32'(flag_a),  32'h0);
    check("reset_pulse", 32'(pulse_a), 32'h0);

    // Count up to 59 then wrap.
    rst = 1'b0; en = 1'b1;
    repeat (59) tick();
    check("up59_cnt",    32'(cnt_a),  32'h59);
    check("up59_flag",   32'(flag_a), 32'h1);
    check("up59_cnt_b",  32'(cnt_b),  32'h059);
    tick();
    check("wrap_cnt",    32'(cnt_a),   32'h00);
    check("wrap_pulse",  32'(pulse_a), 32'h1);
    check("wrap_flag",   32'(flag_a),  32'h0);
    check("wrap_cnt_b",  32'(cnt_b),   32'h100);
    en = 1'b0;
    tick();
    check("pulse_once",  32'(pulse_a), 32'h0);

    // Down mode: direction change alone updates the flag, then wrap from 00.
    up_dn = 1'b0;
    tick();
    check("dn_flag_00",  32'(flag_a), 32'h1);
    en = 1'b1;
    tick();
    check("dn_wrap_cnt",   32'(cnt_a),   32'h59);
    check("dn_wrap_pulse", 32'(pulse_a), 32'h1);
    tick();
    check("dn_58_cnt",     32'(cnt_a),   32'h58);
    check("dn_58_pulse",   32'(pulse_a), 32'h0);
    repeat (60) tick();

    // Saturating load, load wins over en.
    up_dn = 1'b1; load = 1'b1; lv_a = 8'hFC; lv_b = 12'hFFC;
    tick();
    check("load_sat_a",  32'(cnt_a),   32'h59);
    check("load_sat_b",  32'(cnt_b),   32'h159);
    check("load_flag",   32'(flag_a),  32'h1);
    check("load_pulse",  32'(pulse_a), 32'h0);
    load = 1'b0; en = 1'b0;
    tick();
    check("hold_flag",   32'(flag_a),  32'h1);

    // Clear at terminal with en: no wrap pulse.
    en = 1'b1; clr = 1'b1;
    tick();
    check("clr_term_cnt",   32'(cnt_a),   32'h00);
    check("clr_term_pulse", 32'(pulse_a), 32'h0);

    // Clear mid-count, then reset mid-count.
    clr = 1'b0; en = 1'b0; load = 1'b1; lv_a = 8'h39; lv_b = 12'h039;
    tick();
    check("load_39", 32'(cnt_a), 32'h39);
    load = 1'b0; en = 1'b1; clr = 1'b1;
    tick();
    check("clr_mid_cnt",   32'(cnt_a),   32'h00);
    check("clr_mid_pulse", 32'(pulse_a), 32'h0);
    clr = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_cnt",  32'(cnt_a),  32'h00);
    check("rst_mid_flag", 32'(flag_a), 32'h0);
    rst = 1'b0;

    // en toggling: one wrap per 60 enabled edges on the default chain.
    na = 0; nb = 0;
    for (int i = 0; i < 120; i++) begin
      en = (i % 2 == 0);
      tick();
      if (pulse_a) na++;
      if (pulse_b) nb++;
    end
    check("toggle_pulses_a", 32'(na), 32'd1);
    check("toggle_pulses_b", 32'(nb), 32'd0);

    // Continuous count: period 60 vs 120.
    en = 1'b1; na = 0; nb = 0;
    for (int i = 0; i < 240; i++) begin
      tick();
      if (pulse_a) na++;
      if (pulse_b) nb++;
    end
    check("run_pulses_a", 32'(na), 32'd4);
    check("run_pulses_b", 32'(nb), 32'd2);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
